// File: rtl/pwm_decoder_pkg.sv
// rtl/pwm_decoder_pkg.sv - shared types and defaults for the PWM decoder
package pwm_decoder_pkg;

  // Default width of the period/high-time counters and measurement outputs
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Measurement FSM: IDLE waits for the first rise, HIGH/LOW track the gate phase
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_decoder_edge_detect.sv
// rtl/pwm_decoder_edge_detect.sv - gate synchronizer, priming and edge detection
module pwm_edge_detect #(
  parameter int SYNC_STAGES = 0   // 0..2 synchronizer flops
) (
  input  logic clk,
  input  logic rst,
  input  logic gate,
  output logic g,
  output logic rise,
  output logic fall
);

  logic g_prev;
  logic prime;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign g = gate;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;

      // Shift the raw gate through the synchronizer chain
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync <= '0;
        end else begin
          sync[0] <= gate;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync[i] <= sync[i-1];
          end
        end
      end

      assign g = sync[SYNC_STAGES-1];
    end
  endgenerate

  // Remember the previous sample; prime blanks edges in the first cycle after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      g_prev <= 1'b0;
      prime  <= 1'b1;
    end else begin
      g_prev <= g;
      prime  <= 1'b0;
    end
  end

  assign rise = !prime &&  g && !g_prev;
  assign fall = !prime && !g &&  g_prev;

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - measures PWM period and high time with a valid/ready output
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic                 overrun,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_MAX - CNT_ONE;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n, cnt_inc;
  logic [CNT_WIDTH-1:0]   high_cap, high_cap_n;
  logic                   g, rise, fall;
  logic                   at_limit;
  logic                   emit;
  logic                   to_set;

  pwm_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .gate (gate),
    .g    (g),
    .rise (rise),
    .fall (fall)
  );

  // Saturating increment so the counter can never wrap
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  // Next increment would reach the all-ones value: the gate is stuck
  assign at_limit = (cnt >= CNT_LIMIT);

  // State, counter and high-time capture registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      high_cap <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      high_cap <= high_cap_n;
    end
  end

  // Next-state logic: edges advance the phase, a stuck gate falls back to IDLE
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    high_cap_n = high_cap;
    emit       = 1'b0;
    to_set     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          cnt_n   = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_n    = LOW;
          high_cap_n = cnt;
          cnt_n      = cnt_inc;
        end else if (at_limit) begin
          state_n = IDLE;
          cnt_n   = cnt_inc;
          to_set  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          state_n = HIGH;
          cnt_n   = CNT_ONE;
          emit    = 1'b1;
        end else if (at_limit && !g) begin
          state_n = IDLE;
          cnt_n   = cnt_inc;
          to_set  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Measurement register with valid/ready handshake, overrun and timeout flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (emit) begin
        if (!meas_valid || meas_ready) begin
          period     <= cnt;
          high_time  <= high_cap;
          meas_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end

      if (to_set) begin
        timeout <= 1'b1;
      end else if (rise) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter CNT_WIDTH, 16, width of the period and high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, 0, number of gate input synchronizer flops; legal values 0..2.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 Port gate  input  1  PWM gate signal to be measured, such as a buck switch drive.
REQ-006 Port period  output  CNT_WIDTH  clk cycles between two consecutive sampled rising edges.
REQ-007 Port high_time  output  CNT_WIDTH  clk cycles from a rising edge to the following falling edge.
REQ-008 Port meas_valid  output  1  period/high_time hold a measurement not yet accepted.
REQ-009 Port meas_ready  input  1  consumer accepts a measurement when meas_valid && meas_ready.
REQ-010 Port overrun  output  1  sticky: a completed measurement was dropped.
REQ-011 Port timeout  output  1  no edge within 2^CNT_WIDTH-1 cycles; gate is stuck at 0% or 100% duty.

Function
REQ-012 Gate SHALL pass through SYNC_STAGES flops; edge detection compares the synchronized sample g with its previous-cycle value g_prev.
REQ-013 Rise = g && !g_prev; fall = !g && g_prev; no edge SHALL be reported in the first sample cycle after reset (g_prev primed from g).
REQ-014 FSM states: IDLE, HIGH, LOW; IDLE->HIGH on rise, HIGH->LOW on fall, LOW->HIGH on rise; other edges are ignored.
REQ-015 On every rise, counter cnt SHALL load 1; otherwise, outside IDLE, it SHALL increment by 1 per cycle.
REQ-016 On fall in HIGH, the internal register high_cap SHALL capture cnt, equal to the number of cycles g was 1.
REQ-017 On rise in LOW, the module SHALL emit a measurement: period<=cnt, high_time<=high_cap, and meas_valid=1 in the next cycle (latency 1 cycle after the rise sample plus SYNC_STAGES).
REQ-018 The first measurement after reset or timeout SHALL need rise, fall, rise; the IDLE->HIGH rise emits nothing.
REQ-019 While meas_valid && !meas_ready, period/high_time SHALL remain stable.
REQ-020 meas_valid SHALL clear the cycle after a handshake unless a new measurement is emitted in that same cycle; in that case valid stays 1 with the new data.
REQ-021 A measurement completing while meas_valid && !meas_ready SHALL be dropped (old data kept) and overrun set to 1 until reset.
REQ-022 If cnt reaches 2^CNT_WIDTH-1 in HIGH or LOW, the FSM SHALL enter IDLE and timeout SHALL go to 1; no measurement is emitted.
REQ-023 timeout SHALL clear in the cycle after the next rise; a pending valid measurement is unaffected by timeout.
REQ-024 Counters SHALL never wrap; minimum reportable values are period=2 and high_time=1.

Reset
REQ-025 With rst=0 at a clk edge: FSM=IDLE; cnt, high_cap, period and high_time=0; meas_valid, overrun and timeout=0; sync flops and g_prev=0; prime flag set.
REQ-026 Reset mid-period SHALL discard all partial measurements and any pending measurement.

Structure
REQ-027 Package pwm_decoder_pkg SHALL hold the FSM state enum and the default CNT_WIDTH constant.
REQ-028 The synchronizer, priming and edge detection SHALL be one sub-module, pwm_edge_detect (outputs g, rise, fall).

Verification
REQ-029 Gate 3 cycles high, 5 cycles low, repeating; meas_ready=1 -> after the second rise: period=8, high_time=3, meas_valid pulses for 1 cycle every 8 cycles.
REQ-030 Same stimulus, meas_ready=0 for 20 cycles -> first measurement held unchanged, overrun=1; a 1-cycle meas_ready then drops meas_valid.
REQ-031 CNT_WIDTH=4, gate held 0 after one rise -> timeout=1 fifteen cycles after that rise, no valid; PWM resumed -> timeout clears after the rise, first valid one full period later.
REQ-032 Gate already 1 at reset release -> no edge on the first cycle; first valid reports a full period and high time.
REQ-033 Gate 1 high, 1 low -> period=2, high_time=1 every 2 cycles; rst=0 mid-stream -> all outputs 0 next cycle, and valid needs rise, fall, rise again.
